dynamic_period_meter: RTL and testbench

Measures the spacing, in clock cycles, between single-cycle strobes such as the enable output of the dynamic clock divider. It reports each interval and flags when the interval is stable or when strobes have stopped. It sits beside a divider as its inverse: a divider programmed for N produces strobes every N cycles, and this block reports N. The intended uses are closed-loop checking of divider settings and rate monitoring of external enables.

---
 rtl/dcd_pkg.sv | 13 +
 rtl/dynamic_period_meter_if.sv | 12 +
 rtl/period_lock_detect.sv | 51 +++++
 rtl/dynamic_period_meter.sv | 109 ++++++++++
 tb/tb_dynamic_period_meter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dcd_pkg.sv
// rtl/dcd_pkg.sv - shared state encoding and default sizing for the period meter
package dcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_LOCK_COUNT = 4;

endpackage

// File: rtl/dynamic_period_meter_if.sv
// rtl/dynamic_period_meter_if.sv - measurement report bundle between the meter core and its lock detector
interface dynamic_period_meter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             clr;
    logic             locked;

    modport master (output tdata, output tvalid, output clr, input locked);
    modport slave  (input tdata, input tvalid, input clr, output locked);
endinterface

// File: rtl/period_lock_detect.sv
// rtl/period_lock_detect.sv - tracks consecutive equal measurements and raises lock
module period_lock_detect
    import dcd_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dynamic_period_meter_if.slave  meas
);
    localparam int MW = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT - 1);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [MW-1:0]    match_q, match_d;
    logic             locked_q, locked_d;

    // prev is deliberately kept across clears: the first report after re-arming
    // compares against the stale value, and a mismatch merely zeroes the match count
    always_comb begin
        prev_d  = prev_q;
        match_d = match_q;
        if (meas.clr) begin
            match_d = '0;
        end else if (meas.tvalid) begin
            prev_d = meas.tdata;
            if (meas.tdata == prev_q) begin
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
            end else begin
                match_d = '0;
            end
        end
        locked_d = (match_d == MATCH_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    assign meas.locked = locked_q;

endmodule

// File: rtl/dynamic_period_meter.sv
// rtl/dynamic_period_meter.sv - measures cycle spacing between strobes, flags lock and timeout
module dynamic_period_meter
    import dcd_pkg::*;
#(
    parameter int          WIDTH      = DEFAULT_WIDTH,
    parameter int          LOCK_COUNT = DEFAULT_LOCK_COUNT,
    parameter logic [63:0] MAX_PERIOD = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             i_CLK,
    input  logic             i_RESET_N,
    input  logic             i_ENABLE,
    input  logic             i_PULSE,
    output logic [WIDTH-1:0] o_PERIOD,
    output logic             o_VALID,
    output logic             o_LOCKED,
    output logic             o_TIMEOUT
);
    localparam logic [WIDTH-1:0] MAX_CNT = MAX_PERIOD[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             meas_stb;
    logic             lock_clr;

    dynamic_period_meter_if #(.WIDTH(WIDTH)) meas_if ();

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        meas_stb  = 1'b0;
        lock_clr  = 1'b0;
        if (!i_ENABLE) begin
            state_d  = IDLE;
            cnt_d    = '0;
            lock_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (i_PULSE) begin
                        cnt_d   = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // a strobe landing exactly on MAX_CNT is a legal period, not a timeout
                    if (i_PULSE) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        meas_stb = 1'b1;
                        cnt_d    = WIDTH'(1);
                    end else if (cnt_q == MAX_CNT) begin
                        timeout_d = 1'b1;
                        lock_clr  = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign meas_if.tdata  = cnt_q;
    assign meas_if.tvalid = meas_stb;
    assign meas_if.clr    = lock_clr;

    period_lock_detect #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk   (i_CLK),
        .rst_n (i_RESET_N),
        .meas  (meas_if.slave)
    );

    assign o_PERIOD  = period_q;
    assign o_VALID   = valid_q;
    assign o_LOCKED  = meas_if.locked;
    assign o_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_dynamic_period_meter.sv
// tb/tb_dynamic_period_meter.sv - directed and randomized checks of the period meter against a timing model
module tb_dynamic_period_meter;
    localparam int W    = 16;
    localparam int L    = 4;
    localparam int MAXP = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         pulse = 1'b0;
    logic [W-1:0] o_period;
    logic         o_valid, o_locked, o_timeout;

    always #5 clk = ~clk;

    dynamic_period_meter #(
        .WIDTH      (W),
        .LOCK_COUNT (L),
        .MAX_PERIOD (64'(MAXP))
    ) dut (
        .i_CLK     (clk),
        .i_RESET_N (rst_n),
        .i_ENABLE  (en),
        .i_PULSE   (pulse),
        .o_PERIOD  (o_period),
        .o_VALID   (o_valid),
        .o_LOCKED  (o_locked),
        .o_TIMEOUT (o_timeout)
    );

    dynamic_period_meter_if #(.WIDTH(W)) mon_if ();
    assign mon_if.tdata  = o_period;
    assign mon_if.tvalid = o_valid;
    assign mon_if.locked = o_locked;
    assign mon_if.clr    = o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // model: time of last strobe and the run length of equal reports
    typedef enum {M_OFF, M_ARMED, M_MEAS} mmode_e;
    mmode_e mode;
    int     cyc, t_last, exp_period, run;
    bit     exp_valid, exp_timeout;

    function automatic void model_reset();
        mode        = M_OFF;
        cyc         = 0;
        t_last      = 0;
        exp_period  = 0;
        run         = 0;
        exp_valid   = 1'b0;
        exp_timeout = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit p);
        int el;
        exp_valid   = 1'b0;
        exp_timeout = 1'b0;
        if (!e) begin
            mode = M_OFF;
            run  = 0;
        end else if (mode == M_OFF) begin
            mode = M_ARMED;
        end else if (mode == M_ARMED) begin
            if (p) begin
                mode   = M_MEAS;
                t_last = cyc;
            end
        end else begin
            el = cyc - t_last;
            if (p) begin
                exp_valid  = 1'b1;
                run        = (el == exp_period) ? ((run + 1 > L - 1) ? L - 1 : run + 1) : 0;
                exp_period = el;
                t_last     = cyc;
            end else if (el == MAXP) begin
                exp_timeout = 1'b1;
                run         = 0;
                mode        = M_ARMED;
            end
        end
        cyc++;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("period",  int'(mon_if.tdata),  exp_period);
        check("valid",   int'(mon_if.tvalid), int'(exp_valid));
        check("locked",  int'(mon_if.locked), (run == L - 1) ? 1 : 0);
        check("timeout", int'(mon_if.clr),    int'(exp_timeout));
    endtask

    task automatic tick(bit e, bit p);
        en    = e;
        pulse = p;
        @(posedge clk);
        model_step(e, p);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_after(int gap);
        repeat (gap - 1) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
    endtask

    initial begin
        int tcount;
        int gap, reps;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_period",  int'(o_period),  0);
        check("rst_valid",   int'(o_valid),   0);
        check("rst_locked",  int'(o_locked),  0);
        check("rst_timeout", int'(o_timeout), 0);
        rst_n = 1'b1;

        // basic period of 5
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        pulse_after(5);
        check("lit_first_valid",  int'(o_valid),  1);
        check("lit_first_period", int'(o_period), 5);
        pulse_after(5);
        pulse_after(5);
        check("lit_lock_pre4", int'(o_locked), 0);
        pulse_after(5);
        check("lit_lock_4th", int'(o_locked), 1);

        // period change 7 -> 3
        repeat (6) pulse_after(7);
        pulse_after(3);
        check("lit_chg_period", int'(o_period), 3);
        check("lit_chg_unlock", int'(o_locked), 0);
        repeat (3) pulse_after(3);
        check("lit_chg_relock", int'(o_locked), 1);

        // continuous strobe
        repeat (6) tick(1'b1, 1'b1);
        check("lit_cont_period", int'(o_period), 1);
        check("lit_cont_valid",  int'(o_valid),  1);
        check("lit_cont_locked", int'(o_locked), 1);

        // timeout after silence
        tcount = 0;
        repeat (12) begin
            tick(1'b1, 1'b0);
            tcount += int'(o_timeout);
        end
        check("lit_to_once",   tcount,            1);
        check("lit_to_period", int'(o_period),    1);
        check("lit_to_locked", int'(o_locked),    0);
        tick(1'b1, 1'b1);
        check("lit_to_armed_noreport", int'(o_valid), 0);

        // strobe exactly on MAX_PERIOD
        pulse_after(10);
        check("lit_edge_period",  int'(o_period),  10);
        check("lit_edge_timeout", int'(o_timeout), 0);

        // lock at 4 then disable
        repeat (4) pulse_after(4);
        check("lit_dis_prelock", int'(o_locked), 1);
        tick(1'b0, 1'b1);
        check("lit_dis_locked", int'(o_locked), 0);
        check("lit_dis_period", int'(o_period), 4);
        check("lit_dis_valid",  int'(o_valid),  0);

        // asynchronous reset mid-count
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("lit_arst_period",  int'(o_period),  0);
        check("lit_arst_valid",   int'(o_valid),   0);
        check("lit_arst_locked",  int'(o_locked),  0);
        check("lit_arst_timeout", int'(o_timeout), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("lit_post_rst_noreport", int'(o_valid), 0);
        pulse_after(6);
        check("lit_post_rst_period", int'(o_period), 6);

        // randomized spacing, repeats and disables
        for (int s = 0; s < 300; s++) begin
            gap  = $urandom_range(1, 12);
            reps = $urandom_range(1, 6);
            for (int r = 0; r < reps; r++) begin
                if ($urandom_range(0, 30) == 0)
                    tick(1'b0, 1'($urandom_range(0, 1)));
                else
                    pulse_after(gap);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
